// File: rtl/imem_boot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_ctrl_pkg
// Description : Shared definitions for the instruction-memory boot sequencer:
//               stream/word geometry, byte-lane constants and the controller
//               state encoding. Intended to be reused by debug/loader blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_boot_ctrl_pkg;

  // Stream geometry: bytes in, 32-bit words out, 16-bit little-endian header.
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int HDR_W  = 16;

  // Byte lanes per word and the lane that completes a word.
  localparam int                LANES     = WORD_W / BYTE_W;
  localparam int                LANE_W    = 2;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  // Controller states (3-bit encoding, stable for external debug visibility).
  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } boot_state_e;

  // A reload request is only meaningful once loading has finished or failed.
  function automatic logic reload_allowed(input boot_state_e s);
    return (s == ST_RUN) || (s == ST_ERR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_boot_ctrl_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_ctrl_word_packer
// Description : Assembles a 32-bit little-endian word from a byte stream.
//               The first byte of a word lands in bits [7:0].
// Revision    : 1.0 - initial release
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   clear_i      in   drop any partially assembled word, restart at lane 0
//   byte_valid_i in   a byte is accepted this cycle
//   byte_i       in   accepted byte
//   word_o       out  word as it stands including byte_i (valid with word_full_o)
//   word_full_o  out  byte_i completes a word this cycle
// ============================================================================
module imem_boot_ctrl_word_packer
  import imem_boot_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [LANE_W-1:0]        lane_q;
  // Only the three earlier bytes need storage; the fourth arrives on byte_i
  // in the same cycle the full word is consumed.
  logic [WORD_W-BYTE_W-1:0] shift_q;

  assign word_o      = {byte_i, shift_q};
  assign word_full_o = byte_valid_i && (lane_q == LAST_LANE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (clear_i) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (byte_valid_i) begin
      // Lane counter wraps naturally back to 0 after the last lane.
      lane_q  <= lane_q + LANE_W'(1);
      shift_q <= word_o[WORD_W-1:BYTE_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_ctrl
// Description : Boot sequencer for the single-cycle RISC-V core. Holds the
//               core in reset, receives a program image over a byte-serial
//               valid/ready stream (16-bit LE word count, then LE words),
//               writes it into instruction memory, waits HOLD_CYCLES, then
//               releases the core. A reload pulse in RUN or ERR restarts.
// Revision    : 1.0 - initial release
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   ld_valid    in   loader byte valid
//   ld_data     in   loader byte
//   ld_ready    out  byte accepted when ld_valid & ld_ready
//   reload      in   1-cycle restart request (RUN/ERR only)
//   imem_we     out  imem write strobe, one cycle per word
//   imem_addr   out  imem byte address (holds last value outside writes)
//   imem_wdata  out  imem write data
//   core_rst_n  out  core reset, active-low
//   done        out  image loaded and core released
//   err         out  image rejected (too large); sticky until reload
// ============================================================================
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_WORDS = 256,
  parameter int BASE_ADDR   = 0,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [BYTE_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  // Hold counter runs 0..HOLD_CYCLES-1 while in HOLD.
  localparam int                HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       DEPTH_U  = 32'(DEPTH_WORDS);

  boot_state_e       state_q;
  logic [HDR_W-1:0]  n_q;
  logic [HDR_W-1:0]  word_idx_q;
  logic [HOLD_W-1:0] hold_cnt_q;

  logic              ld_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [WORD_W-1:0] imem_wdata_q;
  logic              core_rst_n_q;
  logic              done_q;
  logic              err_q;

  logic              w_accept;
  logic              w_reload_go;
  logic [HDR_W-1:0]  w_hdr_n;
  logic [HDR_W-1:0]  w_word_idx_inc;
  logic [ADDR_W-1:0] addr_d;
  logic [WORD_W-1:0] w_word;
  logic              w_word_full;

  // ld_ready_q is only ever high in the byte-accepting states, so it fully
  // qualifies a transfer.
  assign w_accept       = ld_valid && ld_ready_q;
  assign w_reload_go    = reload && reload_allowed(state_q);
  assign w_hdr_n        = {ld_data, n_q[BYTE_W-1:0]};
  assign w_word_idx_inc = word_idx_q + HDR_W'(1);
  // Cannot wrap: the header check bounds word_idx below DEPTH_WORDS.
  assign addr_d         = BASE_A + ADDR_W'({word_idx_q, 2'b00});

  imem_boot_ctrl_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_reload_go),
    .byte_valid_i (w_accept && (state_q == ST_DATA)),
    .byte_i       (ld_data),
    .word_o       (w_word),
    .word_full_o  (w_word_full)
  );

  // Controller FSM. All outputs are registered: each output register is
  // loaded with the value belonging to the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HDR_LO;
      n_q          <= '0;
      word_idx_q   <= '0;
      hold_cnt_q   <= '0;
      ld_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_A;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse covering the WRITE state only.
      imem_we_q <= 1'b0;

      case (state_q)
        ST_HDR_LO: begin
          // Ready comes up one cycle after reset release.
          ld_ready_q <= 1'b1;
          if (w_accept) begin
            n_q[BYTE_W-1:0] <= ld_data;
            state_q         <= ST_HDR_HI;
          end
        end

        ST_HDR_HI: begin
          if (w_accept) begin
            n_q[HDR_W-1:BYTE_W] <= ld_data;
            if (32'(w_hdr_n) > DEPTH_U) begin
              ld_ready_q <= 1'b0;
              err_q      <= 1'b1;
              state_q    <= ST_ERR;
            end else if (w_hdr_n == '0) begin
              ld_ready_q <= 1'b0;
              hold_cnt_q <= '0;
              state_q    <= ST_HOLD;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (w_word_full) begin
            ld_ready_q   <= 1'b0;
            imem_we_q    <= 1'b1;
            imem_addr_q  <= addr_d;
            imem_wdata_q <= w_word;
            state_q      <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          word_idx_q <= w_word_idx_inc;
          if (w_word_idx_inc == n_q) begin
            hold_cnt_q <= '0;
            state_q    <= ST_HOLD;
          end else begin
            ld_ready_q <= 1'b1;
            state_q    <= ST_DATA;
          end
        end

        ST_HOLD: begin
          if (hold_cnt_q == HOLD_END) begin
            core_rst_n_q <= 1'b1;
            done_q       <= 1'b1;
            state_q      <= ST_RUN;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end

        ST_RUN, ST_ERR: begin
          if (w_reload_go) begin
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ld_ready_q   <= 1'b1;
            n_q          <= '0;
            word_idx_q   <= '0;
            hold_cnt_q   <= '0;
            state_q      <= ST_HDR_LO;
          end
        end

        default: begin
          ld_ready_q <= 1'b0;
          state_q    <= ST_HDR_LO;
        end
      endcase
    end
  end

  assign ld_ready   = ld_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_ctrl
// Description : Directed self-checking bench for imem_boot_ctrl. Expected
//               imem writes are queued as stimulus is sent and compared when
//               the DUT strobes imem_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_ctrl;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 256;
  localparam int BASE   = 0;
  localparam int HOLD   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_data = 8'h00;
  logic              reload = 1'b0;
  logic              ld_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              err;

  int vectors      = 0;
  int miscompares  = 0;
  int cyc          = 0;
  int last_we_cyc  = 0;
  int last_acc_cyc = 0;

  logic [63:0] exp_q[$];   // {addr, data}
  logic [63:0] mon_e;
  logic [31:0] img[$];

  imem_boot_ctrl #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on each strobe.
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      last_we_cyc = cyc;
      check("we_ld_ready_low", {31'b0, ld_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("we_unexpected", {31'b0, imem_we}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr", 32'(imem_addr), mon_e[63:32]);
        check("we_data", imem_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_ready"},   {31'b0, ld_ready},   32'd0);
    check({tag, "_imem_we"},    {31'b0, imem_we},    32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr),      32'(BASE));
    check({tag, "_imem_wdata"}, imem_wdata,          32'd0);
    check({tag, "_core_rst_n"}, {31'b0, core_rst_n}, 32'd0);
    check({tag, "_done"},       {31'b0, done},       32'd0);
    check({tag, "_err"},        {31'b0, err},        32'd0);
  endtask

  // Drive one byte; returns #1 after the edge that transferred it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      while ($urandom_range(1, 0) == 0) begin
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    ld_valid = 1'b1;
    ld_data  = b;
    budget   = 0;
    while (ld_ready !== 1'b1 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (ld_ready !== 1'b1) begin
      check("ld_ready_timeout", {31'b0, ld_ready}, 32'd1);
      ld_valid = 1'b0;
      return;
    end
    last_acc_cyc = cyc;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic send_image(input bit gaps);
    logic [15:0] n;
    n = 16'(img.size());
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({32'(BASE + 4 * i), img[i]});
      for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8], gaps);
    end
  endtask

  // Waits for core release and checks its cycle against the last write
  // (from_we) or the last accepted byte.
  task automatic wait_run(input string tag, input bit from_we);
    int budget;
    int ref_cyc;
    budget = 0;
    while (core_rst_n !== 1'b1 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    ref_cyc = from_we ? last_we_cyc : last_acc_cyc;
    check({tag, "_release_cycle"}, 32'(cyc - ref_cyc), 32'(HOLD + 1));
    check({tag, "_done"},          {31'b0, done},      32'd1);
    check({tag, "_queue_empty"},   32'(exp_q.size()),  32'd0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Step 1: reset, then two-word image at full rate.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("t1_reset");
    rst = 1'b1;
    img = '{32'h00500013, 32'h00a00093};
    send_image(1'b0);
    wait_run("t1", 1'b1);

    // Step 2: reload, same image with random valid gaps.
    pulse_reload();
    check("t2_core_rst_n_after_reload", {31'b0, core_rst_n}, 32'd0);
    check("t2_done_after_reload",       {31'b0, done},       32'd0);
    send_image(1'b1);
    wait_run("t2", 1'b1);

    // Step 3: empty image.
    pulse_reload();
    img.delete();
    send_image(1'b0);
    wait_run("t3", 1'b0);

    // Step 4: oversized header, sticky error, recovery by reload.
    pulse_reload();
    send_byte(8'h2C, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("t4_err",        {31'b0, err},        32'd1);
    check("t4_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("t4_ld_ready",   {31'b0, ld_ready},   32'd0);
    check("t4_done",       {31'b0, done},       32'd0);
    pulse_reload();
    check("t4_err_cleared",    {31'b0, err},      32'd0);
    check("t4_ld_ready_again", {31'b0, ld_ready}, 32'd1);
    img = '{32'h00000137};
    send_image(1'b0);
    wait_run("t4", 1'b1);

    // Step 5: reload from RUN, overwrite word 0.
    pulse_reload();
    check("t5_core_rst_n_low", {31'b0, core_rst_n}, 32'd0);
    check("t5_done_low",       {31'b0, done},       32'd0);
    img = '{32'h0000006F};
    send_image(1'b0);
    wait_run("t5", 1'b1);

    // Step 6: asynchronous reset in the middle of a word.
    pulse_reload();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("t6_async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    img = '{32'h00500013, 32'h00a00093};
    send_image(1'b0);
    wait_run("t6", 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
